bcd4digit_scan: RTL and testbench



---
 rtl/bcd4digit_scan_if.sv | 12 +
 rtl/bcd4digit_scan.sv | 116 +++++++++++
 tb/tb_bcd4digit_scan.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/bcd4digit_scan_if.sv
// Load-side bus of the 4-digit BCD display scanner.
// The master presents a packed BCD word and decimal points with a load strobe.
// The slave reports whether a loaded value is still waiting for a frame boundary.
interface bcd4digit_scan_if;
  logic        load;
  logic [15:0] bcd;
  logic [3:0]  dp;
  logic        pending;

  modport master (output load, output bcd, output dp, input pending);
  modport slave  (input load, input bcd, input dp, output pending);
endinterface

// File: rtl/bcd4digit_scan.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// It double-buffers the value, so a new word only takes effect at a frame boundary.
module bcd4digit_scan #(
  parameter int REFRESH_DIV   = 2000,
  parameter int DIV_WIDTH     = 11,
  parameter int BLANK_LEADING = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  bcd4digit_scan_if.slave        bus,
  output logic [3:0]             an,
  output logic [6:0]             seg,
  output logic                   seg_dp
);

  logic [DIV_WIDTH-1:0] prescaler;
  logic [1:0]           idx;
  logic                 tc;
  logic                 commit;
  logic [19:0]          shadow;
  logic [15:0]          disp_bcd;
  logic [3:0]           disp_dp;
  logic                 pending;
  logic [3:0]           nib;
  logic                 blank3;
  logic                 blank2;
  logic                 blank1;
  logic                 blank;
  logic [6:0]           seg_next;

  assign tc          = (prescaler == DIV_WIDTH'(REFRESH_DIV - 1));
  assign commit      = tc && (idx == 2'd3);
  assign bus.pending = pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      idx       <= '0;
    end else if (tc) begin
      prescaler <= '0;
      idx       <= idx + 2'd1;
    end else begin
      prescaler <= prescaler + DIV_WIDTH'(1);
    end
  end

  // A load landing on the commit edge bypasses the shadow and goes straight to the display.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow   <= '0;
      disp_bcd <= '0;
      disp_dp  <= '0;
      pending  <= 1'b0;
    end else begin
      if (bus.load) begin
        shadow <= {bus.dp, bus.bcd};
      end
      if (commit) begin
        if (bus.load) begin
          disp_bcd <= bus.bcd;
          disp_dp  <= bus.dp;
        end else if (pending) begin
          disp_bcd <= shadow[15:0];
          disp_dp  <= shadow[19:16];
        end
        pending <= 1'b0;
      end else if (bus.load) begin
        pending <= 1'b1;
      end
    end
  end

  // Blanking cascades from the leftmost digit; a non-BCD nibble stops the cascade.
  always_comb begin
    nib    = disp_bcd[{idx, 2'b00} +: 4];
    blank3 = (disp_bcd[15:12] == 4'd0);
    blank2 = blank3 && (disp_bcd[11:8] == 4'd0);
    blank1 = blank2 && (disp_bcd[7:4] == 4'd0);
    case (idx)
      2'd1:    blank = blank1;
      2'd2:    blank = blank2;
      2'd3:    blank = blank3;
      default: blank = 1'b0;
    endcase
    blank = blank && (BLANK_LEADING != 0);
    case (nib)
      4'd0:    seg_next = 7'h40;
      4'd1:    seg_next = 7'h79;
      4'd2:    seg_next = 7'h24;
      4'd3:    seg_next = 7'h30;
      4'd4:    seg_next = 7'h19;
      4'd5:    seg_next = 7'h12;
      4'd6:    seg_next = 7'h02;
      4'd7:    seg_next = 7'h78;
      4'd8:    seg_next = 7'h00;
      4'd9:    seg_next = 7'h10;
      default: seg_next = 7'h3F;
    endcase
    if (blank) begin
      seg_next = 7'h7F;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an     <= 4'b1111;
      seg    <= 7'h7F;
      seg_dp <= 1'b1;
    end else begin
      an     <= ~(4'b0001 << idx);
      seg    <= seg_next;
      seg_dp <= ~disp_dp[idx];
    end
  end

endmodule

// File: tb/tb_bcd4digit_scan.sv
// Randomized and directed bench for bcd4digit_scan.
// A cycle-count reference model predicts every display output.
module tb_bcd4digit_scan;
  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] an;
  logic [6:0] seg;
  logic       seg_dp;

  bcd4digit_scan_if bus ();

  bcd4digit_scan #(.REFRESH_DIV(R), .DIV_WIDTH(2), .BLANK_LEADING(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .an     (an),
    .seg    (seg),
    .seg_dp (seg_dp)
  );

  always #5 clk = ~clk;

  int check_count = 0;
  int fail_count  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    check_count++;
    if (got !== want) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model: position in the frame comes purely from edges counted since reset.
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
  int         cyc = 0;
  bit         started = 0;
  logic [19:0] m_shadow = '0;
  logic [19:0] m_disp = '0;
  logic       m_pend = 1'b0;
  logic [3:0] exp_an = 4'hF;
  logic [6:0] exp_seg = 7'h7F;
  logic       exp_dp = 1'b1;

  function automatic logic [6:0] render(input logic [19:0] v, input int slot);
    int word = int'(v[15:0]);
    if (slot > 0 && (word >> (4 * slot)) == 0) return 7'h7F;
    return seg_tab[(word >> (4 * slot)) % 16];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      cyc = 0; m_shadow = '0; m_disp = '0; m_pend = 1'b0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      started = 1;
    end else begin
      int slot;
      slot    = (cyc / R) % 4;
      exp_an  = ~(4'b0001 << slot);
      exp_seg = render(m_disp, slot);
      exp_dp  = ~m_disp[16 + slot];
      if (cyc % (4 * R) == 4 * R - 1) begin
        if (bus.load) m_disp = {bus.dp, bus.bcd};
        else if (m_pend) m_disp = m_shadow;
        m_pend = 1'b0;
      end else if (bus.load) begin
        m_shadow = {bus.dp, bus.bcd};
        m_pend   = 1'b1;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      checkOutput("an", 32'(an), 32'(exp_an));
      checkOutput("seg", 32'(seg), 32'(exp_seg));
      checkOutput("seg_dp", 32'(seg_dp), 32'(exp_dp));
      checkOutput("pending", 32'(bus.pending), 32'(m_pend));
    end
  end

  task automatic applyStimulus(input logic [15:0] b, input logic [3:0] d);
    bus.bcd  = b;
    bus.dp   = d;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic waitDigit(input int d, output bit ok);
    logic [3:0] want;
    want = ~(4'b0001 << d);
    ok = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (an === want) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic checkDigit(input int d, input logic [6:0] s, input logic p);
    bit ok;
    waitDigit(d, ok);
    if (!ok) checkOutput($sformatf("timeout_d%0d", d), 32'(0), 32'(1));
    else begin
      checkOutput($sformatf("seg_d%0d", d), 32'(seg), 32'(s));
      checkOutput($sformatf("dp_d%0d", d), 32'(seg_dp), 32'(p));
    end
  endtask

  task automatic waitCommitEdge();
    for (int k = 0; k < 64; k++) begin
      if (cyc % (4 * R) == 4 * R - 1) return;
      @(negedge clk);
    end
    checkOutput("timeout_commit", 32'(0), 32'(1));
  endtask

  function automatic logic [15:0] randWord();
    logic [15:0] w;
    for (int i = 0; i < 4; i++) begin
      int r = $urandom_range(0, 9);
      if (r < 3) w[4*i +: 4] = 4'd0;
      else if (r == 3) w[4*i +: 4] = 4'($urandom_range(10, 15));
      else w[4*i +: 4] = 4'($urandom_range(1, 9));
    end
    return w;
  endfunction

  initial begin
    bit ok;
    bus.load = 1'b0;
    bus.bcd  = '0;
    bus.dp   = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_an", 32'(an), 32'(4'hF));
    rst = 1'b0;
    checkDigit(0, 7'h40, 1'b1);
    checkDigit(1, 7'h7F, 1'b1);

    waitDigit(1, ok);
    applyStimulus(16'h1234, 4'b0000);
    checkOutput("pending_after_load", 32'(bus.pending), 32'(1));
    repeat (2 * 4 * R) @(negedge clk);
    checkDigit(0, 7'h19, 1'b1);
    checkDigit(1, 7'h30, 1'b1);
    checkDigit(2, 7'h24, 1'b1);
    checkDigit(3, 7'h79, 1'b1);

    applyStimulus(16'h0050, 4'b0000);
    repeat (2 * 4 * R) @(negedge clk);
    checkDigit(0, 7'h40, 1'b1);
    checkDigit(1, 7'h12, 1'b1);
    checkDigit(2, 7'h7F, 1'b1);
    checkDigit(3, 7'h7F, 1'b1);

    applyStimulus(16'h0000, 4'b0000);
    repeat (2 * 4 * R) @(negedge clk);
    checkDigit(0, 7'h40, 1'b1);
    checkDigit(1, 7'h7F, 1'b1);

    applyStimulus(16'h0105, 4'b0000);
    repeat (2 * 4 * R) @(negedge clk);
    checkDigit(0, 7'h12, 1'b1);
    checkDigit(1, 7'h40, 1'b1);
    checkDigit(2, 7'h79, 1'b1);
    checkDigit(3, 7'h7F, 1'b1);

    applyStimulus(16'h12A4, 4'b0100);
    repeat (2 * 4 * R) @(negedge clk);
    checkDigit(1, 7'h3F, 1'b1);
    checkDigit(2, 7'h24, 1'b0);
    checkDigit(3, 7'h79, 1'b1);

    @(negedge clk);
    waitCommitEdge();
    applyStimulus(16'h5678, 4'b0000);
    checkOutput("pending_load_at_commit", 32'(bus.pending), 32'(0));
    checkDigit(0, 7'h00, 1'b1);

    waitDigit(0, ok);
    applyStimulus(16'h1111, 4'b0000);
    @(negedge clk);
    applyStimulus(16'h2222, 4'b0000);
    repeat (2 * 4 * R) @(negedge clk);
    checkDigit(0, 7'h24, 1'b1);
    checkDigit(3, 7'h24, 1'b1);

    waitDigit(1, ok);
    applyStimulus(16'h9876, 4'b1111);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_reset_an", 32'(an), 32'(4'hF));
    checkOutput("mid_reset_pending", 32'(bus.pending), 32'(0));
    rst = 1'b0;
    checkDigit(0, 7'h40, 1'b1);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 149) == 0);
      bus.load = ($urandom_range(0, 5) == 0);
      bus.bcd  = randWord();
      bus.dp   = 4'($urandom);
    end
    @(negedge clk);
    rst      = 1'b0;
    bus.load = 1'b0;
    repeat (4 * R) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
